// File: rtl/fp_addsub_arbiter.sv
// Round-robin sequencer for the shared single-precision add/sub datapath (two requesters).
// Latency: accept at edge T, rsp_valid from edge T+DP_CYCLES; next accept at T+DP_CYCLES+2 at best.
// Backpressure: holds the captured result in RESP until the owner takes it; no requests accepted meanwhile.
module fp_addsub_arbiter #(
    parameter int DP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_op,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_op,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,

    output logic [31:0] dp_a,
    output logic [31:0] dp_b,
    input  logic [31:0] dp_add_out,
    input  logic [31:0] dp_sub_out,

    output logic        busy,
    output logic [15:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Settle counter is loaded with DP_CYCLES-1 so that DP_CYCLES=1 captures on the first ISSUE edge.
    localparam logic [3:0] CNT_LOAD = 4'(DP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic        last_grant;
    logic        owner;
    logic        op_sel;
    logic [3:0]  cnt;

    logic        grant_vld;
    logic        grant_id;
    logic        accept;
    logic        capture;
    logic        rsp_done;
    logic        owner_rsp_ready;

    // Round-robin grant: only offered in IDLE and never while reset is asserted.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if ((state == IDLE) && !rst) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                grant_id  = 1'b1;
            end
        end
    end

    assign req0_ready = grant_vld && !grant_id;
    assign req1_ready = grant_vld &&  grant_id;

    assign owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the single-cycle strobes that drive the datapath registers.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            IDLE: begin
                // grant_vld already implies the granted requester is valid.
                if (grant_vld) begin
                    accept    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (cnt == 4'd0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                // Returning to IDLE first means a new request is never accepted in the RESP cycle.
                if (owner_rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand, owner, settle counter and result registers; reset aborts any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp_a       <= 32'd0;
            dp_b       <= 32'd0;
            op_sel     <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= 4'd0;
            rsp_result <= 32'd0;
        end else begin
            if (accept) begin
                dp_a       <= grant_id ? req1_a  : req0_a;
                dp_b       <= grant_id ? req1_b  : req0_b;
                op_sel     <= grant_id ? req1_op : req0_op;
                owner      <= grant_id;
                last_grant <= grant_id;
                cnt        <= CNT_LOAD;
            end else if ((state == ISSUE) && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end

            // Result is passed through untouched; special cases belong to the datapath.
            if (capture) begin
                rsp_result <= op_sel ? dp_sub_out : dp_add_out;
            end
        end
    end

    // Completed-response counter, free-running with natural 16-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done <= 16'd0;
        end else if (rsp_done) begin
            ops_done <= ops_done + 16'd1;
        end
    end

    assign rsp0_valid = (state == RESP) && !owner;
    assign rsp1_valid = (state == RESP) &&  owner;
    assign busy       = (state != IDLE);

endmodule

// File: doc/fp_addsub_arbiter.md
# fp_addsub_arbiter

Sequencing and arbitration controller for the shared single-precision add/sub datapath (`add_fp_single` / `sub_fp_single`) in the floating point module. Two requesters, e.g. the FP execute path and the FP divide/sqrt micro-sequencer, present operand pairs over valid/ready handshakes. The block grants one request at a time with round-robin fairness and drives registered, stable operands into the combinational datapath. After a programmable settle time it captures the result and returns it to the winning requester over a second valid/ready handshake.

## Interface
- `DP_CYCLES`, default 1: cycles operands are held stable before the datapath output is sampled, 1..15.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1 each: request present.
- `req0_ready`, `req1_ready`  out  1 each: request accepted this cycle when valid is also high.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  32 each: IEEE-754 single operands.
- `req0_op`, `req1_op`  in  1 each: 0 = a+b, 1 = a−b.
- `rsp0_valid`, `rsp1_valid`  out  1 each: result available for that requester.
- `rsp0_ready`, `rsp1_ready`  in  1 each: requester takes the result.
- `rsp_result`  out  32: captured result, shared by both responses.
- `dp_a`, `dp_b`  out  32 each: registered operands to both datapaths.
- `dp_add_out`, `dp_sub_out`  in  32 each: outputs of the add and sub datapaths.
- `busy`  out  1: state ≠ IDLE.
- `ops_done`  out  16: count of completed response handshakes, wraps 0xFFFF→0.

## Operation
- State machine: IDLE → ISSUE → RESP → IDLE.
- Grant in IDLE, combinational:
  - Only one `reqN_valid` high: that N is granted.
  - Both high: grant the requester ≠ `last_grant`.
  - Neither high: no grant.
  - `reqN_ready` = (state==IDLE) && grant==N.
- Accept when `reqN_valid && reqN_ready`. On that edge:
  - Register `dp_a`, `dp_b`, `op`, and `owner`=N.
  - Set `last_grant`=N, load `cnt`=DP_CYCLES−1, go to ISSUE.
- ISSUE: `dp_a`/`dp_b` held constant.
  - `cnt`≠0: decrement.
  - `cnt`==0: capture `rsp_result` = op ? `dp_sub_out` : `dp_add_out`, go to RESP.
- RESP: `rsp<owner>_valid`=1; the other `rsp_valid`=0.
  - `rsp_result` holds stable until the handshake.
  - On `rsp<owner>_ready`: increment `ops_done`, go to IDLE.
- `rsp_result` is passed through unmodified; the datapath alone handles special cases such as a==b subtract giving 0x00000000.
- Requester inputs are ignored outside IDLE. Operands may change freely once accepted.

## Timing
- Reset values:
  - state=IDLE; `last_grant`=1, so req0 wins the first tie.
  - `req*_ready`=0 during the reset cycle.
  - `rsp*_valid`=0, `rsp_result`=0, `dp_a`=`dp_b`=0, `busy`=0, `ops_done`=0.
- Latency: accept at edge T → `rsp_valid` high from edge T+DP_CYCLES.
- If `rsp_ready` is already high, the handshake completes at edge T+DP_CYCLES+1, and the next accept is possible at edge T+DP_CYCLES+2.
- Peak throughput is one op per DP_CYCLES+2 cycles.
- No same-cycle accept in RESP, even when the response handshake occurs in that cycle.
- Backpressure: with `rsp_ready` low, the block stays in RESP indefinitely. `busy`=1 and both `req_ready`=0.
- `rst` in any state aborts the in-flight op. No response is issued and `ops_done` is not incremented; the next cycle follows reset values.
- `ops_done` at 0xFFFF plus one completion gives 0x0000.

## Test plan
- Single add, DP_CYCLES=1, req0 a=0x3F800000, b=0x3F800000, op=0:
  - Accept at T, `rsp0_valid` at T+1 with `rsp_result`=0x40000000.
  - `rsp1_valid` stays 0; `ops_done`=1.
- Subtract via req1, DP_CYCLES=3, a=0x40400000, b=0x3F800000:
  - `dp_a`/`dp_b` stable for 3 cycles.
  - `rsp1_valid` at T+3 with 0x40000000.
- Equal-operand subtract 0x41200000−0x41200000 → `rsp_result`=0x00000000.
- Both requesters valid continuously for 4 ops:
  - Grant order req0, req1, req0, req1.
  - Each result goes to the correct `rspN_valid`.
  - Accepts spaced DP_CYCLES+2 apart.
- Hold `rsp0_ready` low 5 cycles in RESP:
  - `rsp_result` and `rsp0_valid` stable, both `req_ready`=0, `busy`=1.
  - Release: return to IDLE one cycle later.
- Assert `rst` for one cycle mid-ISSUE (DP_CYCLES=4):
  - No response issued; all outputs at reset values.
  - Following tie is granted to req0.
